// File: rtl/config_chain_loader.sv
// Serial loader: host words go onto the tile config chain LSB-first, then one set strobe; chain tail is captured as readback words.
// Latency: a word accepted in cycle t is shifted in cycles t+1..t+WORD_W; set follows the last chain bit by one cycle.
// Backpressure: s_ready is high only in LOAD. A host stall holds cen low and freezes the chain position.
module config_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1),
    parameter int IDX_W     = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              cen,
    output logic              shift_out,
    output logic              set_out,
    input  logic              chain_return,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SET   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] word_buf;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_take;
    logic              last_bit;
    logic              last_idx;

    assign word_take = s_valid && s_ready;
    assign last_bit  = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign last_idx  = (idx == IDX_W'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The chain-length limit wins over the word boundary, so a partial last word goes straight to SET.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (word_take) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_nxt = ST_SET;
                end else if (last_idx) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_SET: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        cen       = 1'b0;
        shift_out = 1'b0;
        set_out   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_SHIFT: begin
                cen       = 1'b1;
                shift_out = word_buf[0];
                busy      = 1'b1;
            end
            ST_SET: begin
                cen     = 1'b1;
                set_out = 1'b1;
                busy    = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // chain_return is captured on the same edge that clocks the chain, so it reflects the tail bit of this cen cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_buf <= '0;
            idx      <= '0;
            bit_cnt  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            err      <= start && busy;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) bit_cnt <= '0;
                end
                ST_LOAD: begin
                    if (word_take) begin
                        word_buf <= s_data;
                        idx      <= '0;
                        rd_data  <= '0;
                    end
                end
                ST_SHIFT: begin
                    word_buf <= word_buf >> 1;
                    rd_data  <= rd_data | (WORD_W'(chain_return) << idx);
                    idx      <= idx + 1'b1;
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (last_bit || last_idx) rd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: directed load/stall/abort/start-while-busy sessions plus randomized sessions,
// checked against a word-level model of the expected bit stream, readback words and timing.
module tb_config_chain_loader;

    localparam int W      = 8;
    localparam int CL     = 20;
    localparam int NWORDS = (CL + W - 1) / W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         cen;
    logic         shift_out;
    logic         set_out;
    logic         chain_return;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         busy;
    logic         done;
    logic         err;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [W-1:0] fixed_q[$];

    always #5 clk = ~clk;

    config_chain_loader #(
        .WORD_W   (W),
        .CHAIN_LEN(CL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .cen         (cen),
        .shift_out   (shift_out),
        .set_out     (set_out),
        .chain_return(chain_return),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctrl_vec();
        return {s_ready, cen, shift_out, set_out, rd_valid, busy, done, err};
    endfunction

    function automatic logic [W-1:0] next_word();
        if (fixed_q.size() > 0) return fixed_q.pop_front();
        return W'($urandom);
    endfunction

    // Called at #1 after a posedge; returns at #1 after a posedge (or at a negedge with rst low when aborted).
    task automatic run_session(input int stall_pct, input bit ret_high, input int stall_first,
                               input int poke_at, input int abort_at);
        logic [W-1:0] acc_q[$];
        logic [W-1:0] rd_q[$];
        bit           sh_q[$];
        bit           ret_q[$];
        logic [W-1:0] cur;
        logic [W-1:0] w;
        logic [W-1:0] exp_rd;
        int  shifts = 0, sets = 0, errs = 0, run = 0, planned = 0, stall_left = 0;
        int  set_cyc = -1, done_cyc = -1;
        bit  after_run = 0, finished = 0, aborted = 0, poked = 0, shifting = 0, took = 0;

        cur          = next_word();
        start        = 1'b1;
        s_valid      = 1'b1;
        s_data       = cur;
        chain_return = ret_high ? 1'b1 : 1'($urandom_range(1));

        for (int cyc = 0; cyc < 400 && !finished && !aborted; cyc++) begin
            @(negedge clk);
            if (!rst) begin
                @(posedge clk);
                @(negedge clk);
                check_eq("abort_ctrl", 32'(ctrl_vec()), 0);
                check_eq("abort_rd_data", 32'(rd_data), 0);
                check_eq("abort_no_set", sets, 0);
                aborted = 1;
            end else begin
                shifting = cen && !set_out;
                if (run > 0) begin
                    check_eq("cen_run", 32'(shifting), 1);
                    run--;
                    after_run = (run == 0);
                end else begin
                    check_eq("cen_idle", 32'(shifting), 0);
                    if (after_run) begin
                        if (planned < CL) check_eq("ready_back", 32'(s_ready), 1);
                        else              check_eq("set_after_last", 32'(set_out), 1);
                        after_run = 0;
                    end
                end
                if (shifting) begin
                    sh_q.push_back(shift_out);
                    ret_q.push_back(chain_return);
                    shifts++;
                end
                if (set_out) begin
                    sets++;
                    set_cyc = cyc;
                    check_eq("set_bitcnt", shifts, CL);
                    check_eq("set_shift_out", 32'(shift_out), 0);
                    check_eq("set_done_low", 32'(done), 0);
                end
                if (rd_valid) rd_q.push_back(rd_data);
                if (err) errs++;
                if (cyc == 1) check_eq("done_cleared", 32'(done), 0);
                took = s_valid && s_ready;
                if (took) begin
                    acc_q.push_back(cur);
                    run = (CL - planned < W) ? CL - planned : W;
                    planned += run;
                    if (acc_q.size() == 1) stall_left = stall_first;
                end
                if (done && cyc > 0) begin
                    finished = 1;
                    done_cyc = cyc;
                end
            end
            if (!finished && !aborted) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                if (poke_at >= 0 && !poked && shifting && shifts == poke_at) begin
                    start = 1'b1;
                    poked = 1;
                end
                if (abort_at >= 0 && shifts >= abort_at) rst = 1'b0;
                if (took) cur = next_word();
                if (stall_left > 0) begin
                    s_valid = 1'b0;
                    stall_left--;
                end else begin
                    s_valid = ($urandom_range(99) >= stall_pct);
                end
                s_data       = cur;
                chain_return = ret_high ? 1'b1 : 1'($urandom_range(1));
            end
        end

        if (abort_at >= 0) begin
            check_eq("abort_seen", 32'(aborted), 1);
        end else begin
            check_eq("session_finished", 32'(finished), 1);
            check_eq("words_accepted", acc_q.size(), NWORDS);
            check_eq("shift_count", shifts, CL);
            check_eq("set_count", sets, 1);
            check_eq("done_after_set", done_cyc, set_cyc + 1);
            check_eq("err_count", errs, (poke_at >= 0) ? 1 : 0);
            for (int i = 0; i < CL && i < sh_q.size(); i++) begin
                if (i / W < acc_q.size()) begin
                    w = acc_q[i / W];
                    check_eq("shift_bit", 32'(sh_q[i]), 32'(w[i % W]));
                end
            end
            check_eq("rd_count", rd_q.size(), NWORDS);
            for (int k = 0; k < NWORDS && k < rd_q.size(); k++) begin
                exp_rd = '0;
                for (int b = 0; b < W && k * W + b < ret_q.size(); b++) exp_rd[b] = ret_q[k * W + b];
                check_eq("rd_word", 32'(rd_q[k]), 32'(exp_rd));
            end
            // Further offered words must be ignored while DONE holds.
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                s_valid = 1'b1;
                s_data  = W'($urandom);
                @(negedge clk);
                check_eq("done_hold", 32'(ctrl_vec()), 32'h02);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b1;
        s_valid      = 1'b1;
        s_data       = 8'hFF;
        chain_return = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("reset_ctrl", 32'(ctrl_vec()), 0);
            check_eq("reset_rd_data", 32'(rd_data), 0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_eq("idle_ignores_valid", 32'(ctrl_vec()), 0);
        @(posedge clk);
        #1;

        // Full load with chain tail tied high.
        fixed_q = '{8'hA5, 8'h3C, 8'h0F};
        run_session(0, 1'b1, 0, -1, -1);

        // Host stall of five LOAD cycles after the first word.
        fixed_q = '{8'hA5, 8'h3C, 8'h0F};
        run_session(0, 1'b0, W + 5, -1, -1);

        // start pulsed in the middle of shifting.
        fixed_q = '{8'hA5, 8'h3C, 8'h0F};
        run_session(0, 1'b0, 0, 5, -1);

        // Reset mid-session, then a fresh complete session.
        fixed_q = '{8'hA5, 8'h3C, 8'h0F};
        run_session(0, 1'b0, 0, -1, 10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        fixed_q.delete();
        run_session(20, 1'b0, 0, -1, -1);

        for (int s = 0; s < 10; s++) begin
            run_session(int'($urandom_range(40)), 1'b0, 0, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
